// File: rtl/dram_lsu.sv
// Load/store initiator between the core MEM stage and a word-addressed DRAM.
// Sub-word stores are read-modify-write; load lanes are sign/zero-extended.
module dram_lsu #(
  parameter int DRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [2:0]         req_funct3,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [DRAM_AW-1:0] dram_a,
  output logic               dram_we,
  output logic [31:0]        dram_din,
  input  logic [31:0]        dram_spo
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t             state_q, state_d;
  logic [DRAM_AW-1:0] wa_q, wa_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         f3_q, f3_d;
  logic               we_q, we_d;
  logic [31:0]        din_q, din_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic        req_bad;
  logic [4:0]  lane_sh;
  logic [31:0] shifted, load_val, lane_mask, merged;

  // Upper address bits alias onto the DRAM word space.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:DRAM_AW+2];

  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = req_addr[0];
      3'b010:  req_bad = (req_addr[1:0] != 2'b00);
      3'b100:  req_bad = req_we;
      3'b101:  req_bad = req_we | req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  assign lane_sh = {off_q, 3'b000};
  assign shifted = dram_spo >> lane_sh;

  always_comb begin
    load_val = shifted;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // din_q still holds the right-aligned store data while in ACCESS.
  assign lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_sh;
  assign merged    = (dram_spo & ~lane_mask) | ((din_q << lane_sh) & lane_mask);

  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wa_d  = req_addr[DRAM_AW+1:2];
          off_d = req_addr[1:0];
          f3_d  = req_funct3;
          we_d  = req_we;
          if (req_we) din_d = req_wdata;
          if (req_bad) begin
            state_d = RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        err_d = 1'b0;
        if (!we_q) begin
          rdata_d = load_val;
          state_d = RESP;
        end else if (f3_q == 3'b010) begin
          rdata_d = 32'h0;
          state_d = RESP;
        end else begin
          din_d   = merged;
          state_d = WRITE;
        end
      end
      WRITE: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wa_q    <= '0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      din_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dram_a     = wa_q;
  assign dram_din   = din_q;
  // Gating with rst keeps a reset edge from committing an in-flight write.
  assign dram_we    = !rst && (((state_q == ACCESS) && we_q && (f3_q == 3'b010)) ||
                               (state_q == WRITE));

endmodule
